// File: rtl/hc595_chain_driver_pkg.sv
// Shared definitions for the 74HC595 chain driver of the 4x7-segment clock.
//   state_e      : driver FSM states, also exported on the debug state port
//   BITS_PER_595 : bits held by one 74HC595 in the chain
package hc595_chain_driver_pkg;

    localparam int BITS_PER_595 = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

endpackage

// File: rtl/hc595_chain_driver_phase_timer.sv
// Phase timer for the 74HC595 chain driver. Every SCLK low, SCLK high and
// LATCH phase lasts SCLK_DIV+1 clock cycles; this counter measures them.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   load_i      : restart the phase (counter back to 0 on the next edge)
//   phase_end_o : high in the last cycle of the current phase
module hc595_phase_timer #(
    parameter int SCLK_DIV = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic phase_end_o
);

    // At least one bit so SCLK_DIV=0 still has a legal counter.
    localparam int CNT_W = ($clog2(SCLK_DIV + 1) > 0) ? $clog2(SCLK_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign phase_end_o = (cnt == CNT_LAST);

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial output stage of the 4x7-segment clock: shifts an N = 8*NUM_ICS bit
// word into a chain of 74HC595s and then pulses RCLK to present it.
//
// Handshake: trigger_i is a level request sampled only while idle. The edge
// that sees trigger_i=1 in IDLE accepts the request, captures data_i and
// raises busy_o; trigger_i and data_i are ignored while busy_o=1. done_o
// pulses for one cycle in the first idle cycle after the latch pulse, and a
// request seen in that cycle is accepted (back-to-back frames).
//
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   trigger_i  : transmit request
//   data_i     : word to transmit (captured on the accepting edge)
//   busy_o     : transfer in progress
//   done_o     : one-cycle completion pulse
//   sclk_o     : 595 SRCLK
//   data_o     : 595 SER
//   latch_en_o : 595 RCLK
//   state_o    : current FSM state (debug)
module hc595_chain_driver
    import hc595_chain_driver_pkg::*;
#(
    parameter int NUM_ICS   = 2,
    parameter int SCLK_DIV  = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            trigger_i,
    input  logic [BITS_PER_595*NUM_ICS-1:0] data_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            sclk_o,
    output logic                            data_o,
    output logic                            latch_en_o,
    output state_e                          state_o
);

    localparam int N     = BITS_PER_595 * NUM_ICS;
    localparam int BIT_W = $clog2(N);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    state_e           state;
    logic [N-1:0]     shadow;
    logic [N-1:0]     shadow_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic             phase_end;
    logic             timer_load;

    // The bit on SER is always the leading end of the shadow register;
    // advancing to the next bit shifts that end out.
    function automatic logic lead_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    always_comb begin
        shadow_nxt = shadow;
        if (MSB_FIRST) begin
            shadow_nxt = {shadow[N-2:0], 1'b0};
        end else begin
            shadow_nxt = {1'b0, shadow[N-1:1]};
        end
    end

    // Held in reset while idle so the first phase starts from 0 on accept;
    // otherwise restarted at the end of every phase, i.e. on each transition.
    assign timer_load = (state == IDLE) || phase_end;

    hc595_phase_timer #(
        .SCLK_DIV(SCLK_DIV)
    ) u_phase_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .phase_end_o(phase_end)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            shadow     <= '0;
            bit_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            sclk_o     <= 1'b0;
            data_o     <= 1'b0;
            latch_en_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_o     <= 1'b0;
                    latch_en_o <= 1'b0;
                    data_o     <= 1'b0;
                    if (trigger_i) begin
                        shadow  <= data_i;
                        bit_cnt <= '0;
                        busy_o  <= 1'b1;
                        data_o  <= lead_bit(data_i);
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        sclk_o <= 1'b1;
                        state  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        sclk_o <= 1'b0;
                        if (bit_cnt != LAST_BIT) begin
                            // New bit appears with the falling edge, giving a
                            // full phase of setup and hold around each rise.
                            bit_cnt <= bit_cnt + BIT_ONE;
                            shadow  <= shadow_nxt;
                            data_o  <= lead_bit(shadow_nxt);
                            state   <= SHIFT_LO;
                        end else begin
                            latch_en_o <= 1'b1;
                            state      <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        latch_en_o <= 1'b0;
                        data_o     <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hc595_chain_driver.sv
module tb_hc595_chain_driver;
    import hc595_chain_driver_pkg::*;

    localparam int N = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Three instances: 0 = P=1 MSB first, 1 = P=4 MSB first, 2 = P=1 LSB first
    logic         trig    [3];
    logic [N-1:0] din     [3];
    logic         busy_w  [3];
    logic         done_w  [3];
    logic         sclk_w  [3];
    logic         sdat_w  [3];
    logic         latch_w [3];
    state_e       st_w    [3];

    hc595_chain_driver #(.NUM_ICS(2), .SCLK_DIV(0), .MSB_FIRST(1'b1)) u_p1 (
        .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig[0]), .data_i(din[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .sclk_o(sclk_w[0]),
        .data_o(sdat_w[0]), .latch_en_o(latch_w[0]), .state_o(st_w[0]));

    hc595_chain_driver #(.NUM_ICS(2), .SCLK_DIV(3), .MSB_FIRST(1'b1)) u_p4 (
        .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig[1]), .data_i(din[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .sclk_o(sclk_w[1]),
        .data_o(sdat_w[1]), .latch_en_o(latch_w[1]), .state_o(st_w[1]));

    hc595_chain_driver #(.NUM_ICS(2), .SCLK_DIV(0), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig[2]), .data_i(din[2]),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .sclk_o(sclk_w[2]),
        .data_o(sdat_w[2]), .latch_en_o(latch_w[2]), .state_o(st_w[2]));

    // ---------------- scoreboard ----------------
    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] sr      [3];   // 595 chain model: sr[15:8]=IC1, sr[7:0]=IC0
    int           rises_m [3];
    int           lat_cnt [3];
    logic         psclk   [3];
    logic         plat    [3];
    logic [N-1:0] mon_exp;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // 595 chain model: shift on SRCLK rise, copy to outputs on RCLK rise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                rises_m[i] = 0;
                psclk[i]   = 1'b0;
                plat[i]    = 1'b0;
            end else begin
                if (sclk_w[i] && !psclk[i]) begin
                    sr[i] = {sr[i][N-2:0], sdat_w[i]};
                    rises_m[i]++;
                end
                if (sclk_w[i] && latch_w[i]) begin
                    fails++;
                    $display("FAIL latch_vs_sclk inst %0d: latch=1 with sclk=1, required latch=0", i);
                end
                if (latch_w[i] && !plat[i]) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_latch inst %0d: latch pulse with empty queue, required none", i);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (sr[i] !== mon_exp || rises_m[i] != N) begin
                            fails++;
                            $display("FAIL latched_word inst %0d: got %h after %0d rises, required %h after %0d rises",
                                     i, sr[i], rises_m[i], mon_exp, N);
                        end
                    end
                    rises_m[i] = 0;
                    lat_cnt[i]++;
                end
                psclk[i] = sclk_w[i];
                plat[i]  = latch_w[i];
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge while the selected instance is idle. Sample n is
    // taken at the negedge after the n-th edge following the accepting edge.
    task automatic run_frame(input int sel, input logic [N-1:0] d, input logic [N-1:0] e,
                             input int p, input int inject_at);
        int   n, done_n, latch_first, latch_len, hi, lo, bad, rises;
        logic prev;
        n = 0; done_n = -1; latch_first = -1; latch_len = 0;
        hi = 0; lo = 0; bad = 0; rises = 0; prev = 1'b0;
        trig[sel] = 1'b1;
        din[sel]  = d;
        exp_q.push_back(e);
        @(negedge clk);
        din[sel] = ~d;  // mid-frame change must not reach the pins
        check($sformatf("busy_after_accept[%0d]", sel), busy_w[sel], 1);
        while (done_n < 0 && n < 400) begin
            trig[sel] = (n == inject_at);
            if (n == inject_at) din[sel] = 16'($urandom);
            if (sclk_w[sel]) begin
                if (lo != 0 && lo != p) bad++;
                lo = 0;
                if (!prev) rises++;
                hi++;
            end else begin
                if (hi != 0 && hi != p) bad++;
                hi = 0;
                if (!latch_w[sel] && !done_w[sel]) lo++;
            end
            if (latch_w[sel]) begin
                if (latch_first < 0) latch_first = n;
                latch_len++;
            end
            if (done_w[sel]) done_n = n;
            prev = sclk_w[sel];
            if (done_n < 0) begin
                @(negedge clk);
                n++;
            end
        end
        trig[sel] = 1'b0;
        check($sformatf("done_latency[%0d]", sel), done_n, (2 * N + 1) * p);
        check($sformatf("latch_start[%0d]", sel), latch_first, 2 * N * p);
        check($sformatf("latch_len[%0d]", sel), latch_len, p);
        check($sformatf("phase_len_errors[%0d]", sel), bad, 0);
        check($sformatf("sclk_rises[%0d]", sel), rises, N);
        check($sformatf("busy_in_done[%0d]", sel), busy_w[sel], 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           sel;
        logic [N-1:0] data;
        logic [N-1:0] exp_chain;   // {IC1, IC0} seen by the 595 model
        int           p;
    } vec_t;

    vec_t vecs [8];
    int   base;

    initial begin
        for (int i = 0; i < 3; i++) begin
            trig[i] = 1'b0; din[i] = '0; sr[i] = '0; lat_cnt[i] = 0;
        end
        vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 1};
        vecs[1] = '{0, 16'h0000, 16'h0000, 1};
        vecs[2] = '{0, 16'hFFFF, 16'hFFFF, 1};
        vecs[3] = '{0, 16'h8001, 16'h8001, 1};
        vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 4};
        vecs[5] = '{2, 16'h0001, 16'h8000, 1};
        vecs[6] = '{2, 16'hA5C3, 16'hC3A5, 1};
        vecs[7] = '{1, 16'h1234, 16'h1234, 4};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy[%0d]", i), busy_w[i], 0);
            check($sformatf("rst_done[%0d]", i), done_w[i], 0);
            check($sformatf("rst_sclk[%0d]", i), sclk_w[i], 0);
            check($sformatf("rst_data[%0d]", i), sdat_w[i], 0);
            check($sformatf("rst_latch[%0d]", i), latch_w[i], 0);
            check($sformatf("rst_state[%0d]", i), int'(st_w[i]), int'(IDLE));
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].sel, vecs[v].data, vecs[v].exp_chain, vecs[v].p, -1);
            repeat (2) @(negedge clk);
        end

        // Trigger pulse while busy: ignored, exactly one frame.
        base = lat_cnt[0];
        run_frame(0, 16'h3C96, 16'h3C96, 1, 10);
        repeat (40) @(negedge clk);
        check("busy_trigger_frames", lat_cnt[0] - base, 1);
        check("busy_trigger_queue", exp_q.size(), 0);

        // Trigger tied high, data changing every cycle: frame every 34 cycles.
        base = lat_cnt[0];
        for (int k = 0; k <= 102; k++) begin
            if (k > 0) begin
                check($sformatf("cont_done_k%0d", k), done_w[0], ((k % 34) == 0) ? 1 : 0);
                check($sformatf("cont_busy_k%0d", k), busy_w[0], ((k % 34) != 0) ? 1 : 0);
            end
            if (k < 102) begin
                trig[0] = 1'b1;
                din[0]  = 16'($urandom);
                if ((k % 34) == 0) exp_q.push_back(din[0]);
            end else begin
                trig[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("cont_frames", lat_cnt[0] - base, 3);
        check("cont_idle_after", busy_w[0], 0);

        // Asynchronous reset during SHIFT_HI of bit 5.
        base = lat_cnt[0];
        trig[0] = 1'b1;
        din[0]  = 16'hFFFF;
        @(negedge clk);
        trig[0] = 1'b0;
        repeat (11) @(negedge clk);
        check("midrst_state_before", int'(st_w[0]), int'(SHIFT_HI));
        check("midrst_sclk_before", sclk_w[0], 1);
        check("midrst_data_before", sdat_w[0], 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sclk", sclk_w[0], 0);
        check("midrst_data", sdat_w[0], 0);
        check("midrst_latch", latch_w[0], 0);
        check("midrst_busy", busy_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_no_latch", lat_cnt[0] - base, 0);
        check("midrst_idle", int'(st_w[0]), int'(IDLE));
        check("midrst_busy_after", busy_w[0], 0);

        check("queue_empty_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
